bf_sweep_ctrl: RTL

Sequential stimulus-and-capture stage that wraps a 3-input boolean-function block. It sweeps all 8 input patterns into the function's inA/inB/inC inputs and holds each pattern for a programmable settle time. It samples the function's output into an 8-bit truth table and compares that table against an expected value. It replaces the free-running toggle stimulus with a synthesizable, self-checking sweep that has a start/done handshake.

---
 rtl/bf_sweep_pkg.sv | 15 +
 rtl/bf_dwell_timer.sv | 30 +++
 rtl/bf_sweep_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bf_sweep_pkg.sv
// Shared types and sizes for the boolean-function sweep controller.
package bf_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int N_PAT = 8;
    localparam int IDX_W = 3;
    localparam int ERR_W = 4;

endpackage

// File: rtl/bf_dwell_timer.sv
// Settle-time counter: counts while enabled, flags the last cycle of the dwell window.
module bf_dwell_timer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;

    // dwell counter, clear has priority over count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire = (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/bf_sweep_ctrl.sv
// Sweeps all 8 patterns into a 3-input function, captures its truth table
// and compares it against an expected table.
module bf_sweep_ctrl
    import bf_sweep_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       outA,
    output logic       outB,
    output logic       outC,
    input  logic       fIn,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,  // "table" is a reserved word
    output logic       match,
    output logic [3:0] errCnt
);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_PAT-1:0]   tbl_q;
    logic [N_PAT-1:0]   tbl_d;
    logic [ERR_W-1:0]   err_q;
    logic [ERR_W-1:0]   err_d;
    logic               busy_q;
    logic               done_q;
    logic               match_q;
    logic               accept_s;
    logic               expire_s;
    logic               last_s;

    assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_s   = (idx_q == IDX_W'(N_PAT - 1));

    bf_dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_s || (state_q == CAPTURE)),
        .en     (state_q == SETTLE),
        .expire (expire_s)
    );

    // table and error count as they will be after capturing the current pattern
    always_comb begin
        tbl_d        = tbl_q;
        tbl_d[idx_q] = fIn;
        if (fIn != expected[idx_q]) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // sweep FSM with registered pattern drive and results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            tbl_q   <= {N_PAT{1'b0}};
            err_q   <= {ERR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        idx_q   <= {IDX_W{1'b0}};
                        tbl_q   <= {N_PAT{1'b0}};
                        err_q   <= {ERR_W{1'b0}};
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        match_q <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                SETTLE: begin
                    if (expire_s) begin
                        state_q <= CAPTURE;
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                CAPTURE: begin
                    tbl_q <= tbl_d;
                    err_q <= err_d;
                    if (last_s) begin
                        state_q <= DONE;
                        idx_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= (err_d == {ERR_W{1'b0}});
                    end else begin
                        state_q <= SETTLE;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {outA, outB, outC} = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tbl_q;
    assign match       = match_q;
    assign errCnt      = err_q;

endmodule
